// File: rtl/qfix_pkg.sv
// qfix_pkg: shared Q-format constants and the accumulator state encoding.
//   Q_DEF / N_DEF : default fractional bits / word width of the multiply chain
//   QMAX / QMIN   : N_DEF-bit signed extremes
//   Q_ONE         : fixed-point 1.0 (1 << Q_DEF)
//   state_t       : IDLE / ACC / HOLD
package qfix_pkg;

  localparam int unsigned Q_DEF = 16;
  localparam int unsigned N_DEF = 32;

  localparam logic signed [N_DEF-1:0] QMAX  = {1'b0, {(N_DEF-1){1'b1}}};
  localparam logic signed [N_DEF-1:0] QMIN  = {1'b1, {(N_DEF-1){1'b0}}};
  localparam logic signed [N_DEF-1:0] Q_ONE = N_DEF'(1) << Q_DEF;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    HOLD
  } state_t;

endpackage

// File: rtl/qmac_accum_if.sv
// qmac_accum_if: term input stream and result output stream of qmac_accum.
//   i_start            : one-cycle pulse opening a new accumulation
//   i_valid / o_ready  : term handshake, payload i_product (N) + i_ovr
//   o_valid / i_ready  : result handshake, payload o_sum (N) + o_ovr
//   o_busy             : accumulator is in ACC or HOLD
// Modports: slave = the accumulator, master = its driver/consumer side.
interface qmac_accum_if
  import qfix_pkg::*;
#(
  parameter int unsigned N = N_DEF
) ();

  logic         i_start;
  logic         i_valid;
  logic         o_ready;
  logic [N-1:0] i_product;
  logic         i_ovr;
  logic         o_valid;
  logic         i_ready;
  logic [N-1:0] o_sum;
  logic         o_ovr;
  logic         o_busy;

  modport slave (
    input  i_start, i_valid, i_product, i_ovr, i_ready,
    output o_ready, o_valid, o_sum, o_ovr, o_busy
  );

  modport master (
    output i_start, i_valid, i_product, i_ovr, i_ready,
    input  o_ready, o_valid, o_sum, o_ovr, o_busy
  );

endinterface

// File: rtl/qsat.sv
// qsat: combinational narrowing of an (N+G)-bit signed value to N bits.
//   value     : N+G-bit signed input
//   result    : N-bit narrowed value
//   range_ovr : value lies outside the N-bit signed range
// Build option QMAC_ACCUM_SAT_EN: when defined, out-of-range values clamp
// to the N-bit signed extreme of matching sign; otherwise the low N bits
// are passed through (two's-complement wrap).
module qsat
  import qfix_pkg::*;
#(
  parameter int unsigned N = N_DEF,
  parameter int unsigned G = 8
) (
  input  logic signed [N+G-1:0] value,
  output logic        [N-1:0]   result,
  output logic                  range_ovr
);

  // In range exactly when the guard bits and the N-bit sign bit all agree.
  logic [G:0] top;

  always_comb begin
    top       = value[N+G-1:N-1];
    range_ovr = !((&top) || !(|top));
  end

`ifdef QMAC_ACCUM_SAT_EN
  always_comb begin
    result = value[N-1:0];
    if (range_ovr) begin
      result = value[N+G-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end
  end
`else
  always_comb begin
    result = value[N-1:0];
  end
`endif

endmodule

// File: rtl/qmac_accum.sv
// qmac_accum: sums LEN signed Q-format products into an (N+G)-bit register
// and presents the N-bit result with a sticky overflow flag.
//   i_clk  : clock, rising edge
//   i_rstn : asynchronous active-low reset
//   bus    : qmac_accum_if.slave (term stream in, result stream out)
// Parameters: Q fractional bits, N word width, LEN terms per result,
// G guard bits (LEN <= 2**G keeps the accumulator wrap-free).
// Build option QMAC_ACCUM_SAT_EN selects saturation of o_sum inside qsat.
module qmac_accum
  import qfix_pkg::*;
#(
  parameter int unsigned Q   = Q_DEF,
  parameter int unsigned N   = N_DEF,
  parameter int unsigned LEN = 16,
  parameter int unsigned G   = 8
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  qmac_accum_if.slave  bus
);

  localparam int unsigned W  = N + G;
  localparam int unsigned CW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  generate
    if (LEN < 1 || 64'(LEN) > (64'd1 << G)) begin : g_len_chk
      $error("qmac_accum: LEN must be in [1, 2**G]");
    end
    if (Q >= N) begin : g_q_chk
      $error("qmac_accum: Q must be smaller than N");
    end
  endgenerate

  state_t state_q, state_d;

  logic signed [W-1:0]  acc_q;
  logic signed [W-1:0]  term_ext;
  logic signed [W-1:0]  acc_sum;
  logic        [CW-1:0] cnt_q;
  logic                 sticky_q;
  logic        [N-1:0]  sum_q;
  logic                 ovr_q;

  logic                 accept;
  logic                 last_accept;
  logic                 clear;
  logic                 ready;
  logic        [N-1:0]  nar_sum;
  logic                 range_ovr;

  // Operands share the accumulator's Q point, so only sign extension is needed.
  always_comb begin
    term_ext = {{G{bus.i_product[N-1]}}, bus.i_product};
    acc_sum  = acc_q + term_ext;
  end

  qsat #(
    .N (N),
    .G (G)
  ) u_qsat (
    .value     (acc_sum),
    .result    (nar_sum),
    .range_ovr (range_ovr)
  );

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    last_accept = 1'b0;
    clear       = 1'b0;
    ready       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          state_d = ACC;
          clear   = 1'b1;
        end
      end
      ACC: begin
        ready = 1'b1;
        if (bus.i_valid) begin
          accept = 1'b1;
          if (cnt_q == LAST) begin
            last_accept = 1'b1;
            state_d     = HOLD;
          end
        end
      end
      HOLD: begin
        // A start coinciding with the result handshake skips IDLE.
        if (bus.i_ready) begin
          if (bus.i_start) begin
            state_d = ACC;
            clear   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      sum_q    <= '0;
      ovr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (clear) begin
        acc_q    <= '0;
        cnt_q    <= '0;
        sticky_q <= 1'b0;
      end else if (accept) begin
        acc_q    <= acc_sum;
        cnt_q    <= cnt_q + 1'b1;
        sticky_q <= sticky_q | bus.i_ovr;
      end
      // Result is taken from acc + final term, not from the updated acc_q.
      if (last_accept) begin
        sum_q <= nar_sum;
        ovr_q <= sticky_q | bus.i_ovr | range_ovr;
      end
    end
  end

  assign bus.o_ready = ready;
  assign bus.o_valid = (state_q == HOLD);
  assign bus.o_busy  = (state_q != IDLE);
  assign bus.o_sum   = sum_q;
  assign bus.o_ovr   = ovr_q;

endmodule
